cn_msg_recover_serial: RTL and testbench
========================================

// Module: cn_msg_recover_serial
// PURPOSE
//  Next-generation LDPC min-sum check-node recovery. Expands one compressed check-node word
//  (min1, min2, min1 index, per-edge signs) into WC signed W-bit extrinsic messages, P per beat.
//  Adds offset/normalised correction, ready/valid on both sides and a bad-index flag.
//  Sits between the check-node compressed message store and the variable-node update.
// PARAMETERS
//  WC      32              check-node degree (edges per frame); WC % P == 0
//  WC_BITS $clog2(WC)      index field width
//  W       10              message width, two's complement; magnitudes are W-1 bits
//  P       8               messages per output beat; NBEATS = WC/P
//  OFF_W   4               offset width
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-low reset
//  in_valid   in   1              compressed word present
//  in_ready   out  1              block accepts this cycle
//  in_data    in   2(W-1)+WC_BITS+WC  {min1, min2, idx, sign[WC-1:0]}, MSB first
//  mode       in   2              0 plain, 1 offset, 2 normalised x3/4, 3 = plain
//  offset     in   OFF_W          offset for mode 1
//  out_valid  out  1              beat valid
//  out_ready  in   1              downstream accepts beat
//  out_data   out  P*W            lane j = message (beat*P + j), lane 0 in LSBs
//  out_beat   out  $clog2(NBEATS) beat number within frame (width min 1)
//  out_last   out  1              beat == NBEATS-1
//  out_err    out  1              idx >= WC for this frame (all beats)
//  frame_cnt  out  16             completed frames, wraps at 2^16
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_beat=0, out_last=0, out_err=0, frame_cnt=0,
//    context empty, so in_ready=1 after reset. Reset mid-frame discards the frame.
//  - Accept on in_valid & in_ready: context register loads corrected m1c/m2c, idx, sign,
//    parity = XOR(sign), err = (idx >= WC). mode/offset sampled at accept, held for frame.
//  - Correction per magnitude m: plain m; offset max(m-offset,0); normalised m-(m>>2).
//  - Message i: mag = (i==idx) ? m2c : m1c; s = parity ^ sign[i]; value = s ? -mag : mag.
//    -mag never overflows (mag <= 2^(W-1)-1). min2 < min1 passed through unchecked.
//    idx >= WC: every edge takes m1c, out_err=1.
//  - Output register loads beat b from context when (!out_valid | out_ready) & ctx full.
//    out_data/out_beat/out_last/out_err stay stable while out_valid & !out_ready.
//  - Beat counter advances on each load; after the last beat loads, context frees.
//  - in_ready = !ctx_full | (loading last beat this cycle). Combinational on out_ready.
//    Back-to-back frames therefore stream with no bubble.
//  - Latency: accept at edge T -> beat 0 registered at T+1 (out_valid high after T+1).
//    Throughput: one frame per NBEATS cycles with out_ready held high.
//  - frame_cnt increments when a beat with out_last is taken (out_valid & out_ready).
// STRUCTURE
//  - cn_recover_pkg: mode encodings (MODE_PLAIN/OFFSET/NORM), field-offset functions
//    for in_data, beat-count function.
//  - Sub-module cn_mag_correct: combinational correction of one magnitude. Instantiated
//    twice, for min1 and min2.
//  - Top holds context register, beat counter, output register, lane mux (P lanes).
// TESTING (WC=32, P=8, W=10 unless noted)
//  - Plain: min1=5, min2=9, idx=3, sign=32'h8. Expect out[3]=+9, all others -5 (10'h3FB).
//    4 beats, out_last on beat 3, frame_cnt=1.
//  - Offset=2, same word: out[3]=+7, others -3. Offset=12 gives 0 on all edges (no -0).
//  - Normalised, same word: out[3]=+7, others -4. Mode changed mid-frame does not alter
//    the remaining beats.
//  - Backpressure: out_ready low 5 cycles at beat 1. Outputs frozen, in_ready=0, no beat
//    lost or duplicated. Two back-to-back frames with out_ready=1 give 8 contiguous beats.
//  - WC=24, P=8, idx=30: out_err=1 on all 3 beats, every edge uses min1.
//  - Assert rst mid-beat 2: outputs clear immediately, frame_cnt=0. Next frame decodes
//    correctly from beat 0.

Source files
------------

// File: rtl/cn_recover_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cn_recover_pkg : shared encodings and field helpers for check-node recovery
// Revision 1.0
// ---------------------------------------------------------------------------
package cn_recover_pkg;

  localparam logic [1:0] MODE_PLAIN  = 2'd0;
  localparam logic [1:0] MODE_OFFSET = 2'd1;
  localparam logic [1:0] MODE_NORM   = 2'd2;

  // in_data is packed {min1, min2, idx, sign[WC-1:0]} with sign in the LSBs
  function automatic int idx_lsb(input int wc);
    return wc;
  endfunction

  function automatic int min2_lsb(input int wc, input int wcb);
    return wc + wcb;
  endfunction

  function automatic int min1_lsb(input int wc, input int wcb, input int mw);
    return wc + wcb + mw;
  endfunction

  function automatic int nbeats(input int wc, input int p);
    return wc / p;
  endfunction

  function automatic int beat_bits(input int wc, input int p);
    return (wc / p > 1) ? $clog2(wc / p) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cn_mag_correct.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cn_mag_correct : combinational offset / normalised correction of one magnitude
// Revision 1.0
// ---------------------------------------------------------------------------
module cn_mag_correct
  import cn_recover_pkg::*;
#(
  parameter int MW    = 9,
  parameter int OFF_W = 4
) (
  input  logic [MW-1:0]    mag,
  input  logic [1:0]       mode,
  input  logic [OFF_W-1:0] offset,
  output logic [MW-1:0]    corr
);

  localparam int XW = (MW > OFF_W) ? MW : OFF_W;

  logic [XW-1:0] mag_x;
  logic [XW-1:0] off_x;

  assign mag_x = XW'(mag);
  assign off_x = XW'(offset);

  always_comb begin
    corr = mag;
    case (mode)
      MODE_OFFSET: corr = (mag_x > off_x) ? MW'(mag_x - off_x) : '0;
      MODE_NORM:   corr = mag - (mag >> 2);
      default:     corr = mag;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cn_msg_recover_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cn_msg_recover_serial : expands a compressed check-node word into P messages per beat
// Revision 1.0
// ---------------------------------------------------------------------------
module cn_msg_recover_serial
  import cn_recover_pkg::*;
#(
  parameter int WC      = 32,
  parameter int WC_BITS = $clog2(WC),
  parameter int W       = 10,
  parameter int P       = 8,
  parameter int OFF_W   = 4,
  localparam int MW     = W - 1,
  localparam int NBEATS = nbeats(WC, P),
  localparam int BW     = beat_bits(WC, P),
  localparam int DW     = 2 * MW + WC_BITS + WC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [1:0]       mode,
  input  logic [OFF_W-1:0] offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P*W-1:0]   out_data,
  output logic [BW-1:0]    out_beat,
  output logic             out_last,
  output logic             out_err,
  output logic [15:0]      frame_cnt
);

  logic [MW-1:0]      in_min1, in_min2, m1c_in, m2c_in;
  logic [WC_BITS-1:0] in_idx;
  logic [WC-1:0]      in_sign;

  assign in_sign = in_data[WC-1:0];
  assign in_idx  = in_data[idx_lsb(WC) +: WC_BITS];
  assign in_min2 = in_data[min2_lsb(WC, WC_BITS) +: MW];
  assign in_min1 = in_data[min1_lsb(WC, WC_BITS, MW) +: MW];

  cn_mag_correct #(.MW(MW), .OFF_W(OFF_W)) u_corr_min1 (
    .mag(in_min1), .mode(mode), .offset(offset), .corr(m1c_in)
  );
  cn_mag_correct #(.MW(MW), .OFF_W(OFF_W)) u_corr_min2 (
    .mag(in_min2), .mode(mode), .offset(offset), .corr(m2c_in)
  );

  logic               ctx_full, ctx_parity, ctx_err;
  logic [MW-1:0]      ctx_m1, ctx_m2;
  logic [WC_BITS-1:0] ctx_idx;
  logic [WC-1:0]      ctx_sign;
  logic [BW-1:0]      beat_cnt;
  logic               load, beat_last, load_last, accept;
  logic [P*W-1:0]     lanes;

  assign load      = (!out_valid || out_ready) && ctx_full;
  assign beat_last = (beat_cnt == BW'(NBEATS - 1));
  assign load_last = load && beat_last;
  // Freeing the context on the last-beat load lets the next frame stream without a gap
  assign in_ready  = !ctx_full || load_last;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctx_full   <= 1'b0;
      ctx_m1     <= '0;
      ctx_m2     <= '0;
      ctx_idx    <= '0;
      ctx_sign   <= '0;
      ctx_parity <= 1'b0;
      ctx_err    <= 1'b0;
    end else if (accept) begin
      ctx_full   <= 1'b1;
      ctx_m1     <= m1c_in;
      ctx_m2     <= m2c_in;
      ctx_idx    <= in_idx;
      ctx_sign   <= in_sign;
      ctx_parity <= ^in_sign;
      ctx_err    <= ({1'b0, in_idx} >= (WC_BITS + 1)'(WC));
    end else if (load_last) begin
      ctx_full   <= 1'b0;
    end
  end

  // An out-of-range idx never matches an edge, so every lane falls back to min1
  for (genvar j = 0; j < P; j++) begin : g_lane
    logic [WC_BITS-1:0] edge_id;
    logic [MW-1:0]      mag;
    logic               neg;
    assign edge_id = WC_BITS'(int'(beat_cnt) * P + j);
    assign mag     = (edge_id == ctx_idx) ? ctx_m2 : ctx_m1;
    assign neg     = ctx_parity ^ ctx_sign[edge_id];
    assign lanes[j*W +: W] = neg ? -{1'b0, mag} : {1'b0, mag};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beat  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (load) begin
      beat_cnt  <= beat_last ? '0 : beat_cnt + 1'b1;
      out_valid <= 1'b1;
      out_data  <= lanes;
      out_beat  <= beat_cnt;
      out_last  <= beat_last;
      out_err   <= ctx_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready && out_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cn_msg_recover_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cn_msg_recover_serial : directed bench for the serial check-node recovery block
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cn_msg_recover_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_err;
  logic [54:0] in_data;
  logic [1:0]  mode;
  logic [3:0]  offset;
  logic [79:0] out_data;
  logic [1:0]  out_beat;
  logic [15:0] frame_cnt;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, out_err_b;
  logic [46:0] in_data_b;
  logic [79:0] out_data_b;
  logic [1:0]  out_beat_b;
  logic [15:0] frame_cnt_b;

  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;
  logic [79:0] held;

  always #5 clk = ~clk;

  cn_msg_recover_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beat(out_beat), .out_last(out_last), .out_err(out_err),
    .frame_cnt(frame_cnt)
  );

  cn_msg_recover_serial #(.WC(24)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .mode(2'd0), .offset(4'd0), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_beat(out_beat_b), .out_last(out_last_b), .out_err(out_err_b),
    .frame_cnt(frame_cnt_b)
  );

  // Reference messages for one beat from already-corrected magnitudes
  function automatic logic [79:0] exp_beat(input int b, input int m1c, input int m2c,
                                           input int idx, input logic [31:0] sign, input int wc);
    logic [79:0] r;
    logic        par;
    int          e, mag;
    par = 1'b0;
    for (int i = 0; i < wc; i++) par ^= sign[i];
    for (int j = 0; j < 8; j++) begin
      e   = b * 8 + j;
      mag = (e == idx) ? m2c : m1c;
      r[j*10 +: 10] = (par ^ sign[e]) ? 10'(-mag) : 10'(mag);
    end
    return r;
  endfunction

  function automatic logic [54:0] pack32(input int m1, input int m2, input int idx,
                                         input logic [31:0] sign);
    return {9'(m1), 9'(m2), 5'(idx), sign};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send32(input logic [54:0] d, input logic [1:0] m, input logic [3:0] off);
    in_data  = d;
    mode     = m;
    offset   = off;
    in_valid = 1'b1;
    chk("in_ready_idle", 80'(in_ready), 80'(1));
    tick();
    in_valid = 1'b0;
    chk("latency_no_valid", 80'(out_valid), 80'(0));
  endtask

  task automatic expect32(input string tag, input int m1c, input int m2c);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk({tag, "_valid"}, 80'(out_valid), 80'(1));
      chk({tag, "_beat"},  80'(out_beat), 80'(b));
      chk({tag, "_last"},  80'(out_last), 80'(b == 3));
      chk({tag, "_err"},   80'(out_err), 80'(0));
      chk({tag, "_data"},  out_data, exp_beat(b, m1c, m2c, 3, 32'h8, 32));
    end
    tick();
    exp_fc++;
    chk({tag, "_idle"}, 80'(out_valid), 80'(0));
    chk({tag, "_fcnt"}, 80'(frame_cnt), 80'(exp_fc));
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; mode = 2'd0; offset = 4'd0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 80'(out_valid), 80'(0));
    chk("rst_data",  out_data, 80'(0));
    chk("rst_fcnt",  80'(frame_cnt), 80'(0));
    chk("rst_ready", 80'(in_ready), 80'(1));
    chk("rst_err",   80'(out_err), 80'(0));
    rst = 1'b1;
    tick();

    send32(pack32(5, 9, 3, 32'h8), 2'd0, 4'd0);
    expect32("plain", 5, 9);
    send32(pack32(5, 9, 3, 32'h8), 2'd1, 4'd2);
    expect32("off2", 3, 7);
    send32(pack32(5, 9, 3, 32'h8), 2'd1, 4'd12);
    expect32("off12", 0, 0);
    send32(pack32(5, 9, 3, 32'h8), 2'd2, 4'd0);
    mode = 2'd1; offset = 4'd15;
    expect32("norm", 4, 7);
    mode = 2'd0; offset = 4'd0;

    // Stall at beat 1: everything must hold and no new word may enter
    send32(pack32(5, 9, 3, 32'h8), 2'd0, 4'd0);
    tick();
    tick();
    chk("bp_beat1", 80'(out_beat), 80'(1));
    held = out_data;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 80'(out_valid), 80'(1));
      chk("bp_beat",  80'(out_beat), 80'(1));
      chk("bp_data",  out_data, held);
      chk("bp_ready", 80'(in_ready), 80'(0));
    end
    out_ready = 1'b1;
    for (int b = 2; b < 4; b++) begin
      tick();
      chk("bp_resume_beat", 80'(out_beat), 80'(b));
      chk("bp_resume_data", out_data, exp_beat(b, 5, 9, 3, 32'h8, 32));
    end
    tick();
    exp_fc++;
    chk("bp_idle", 80'(out_valid), 80'(0));
    chk("bp_fcnt", 80'(frame_cnt), 80'(exp_fc));

    // Back-to-back: plain frame then offset-2 frame, 8 contiguous beats
    in_data = pack32(5, 9, 3, 32'h8); mode = 2'd0; offset = 4'd0; in_valid = 1'b1;
    tick();
    in_data = pack32(5, 9, 3, 32'h8); mode = 2'd1; offset = 4'd2;
    chk("b2b_latency", 80'(out_valid), 80'(0));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_valid", 80'(out_valid), 80'(1));
      chk("b2b_beat",  80'(out_beat), 80'(k % 4));
      chk("b2b_data",  out_data, (k < 4) ? exp_beat(k, 5, 9, 3, 32'h8, 32)
                                         : exp_beat(k - 4, 3, 7, 3, 32'h8, 32));
      if (k < 3) chk("b2b_in_ready", 80'(in_ready), 80'(k == 2));
      if (k == 3) in_valid = 1'b0;
    end
    tick();
    exp_fc += 2;
    chk("b2b_idle", 80'(out_valid), 80'(0));
    chk("b2b_fcnt", 80'(frame_cnt), 80'(exp_fc));
    mode = 2'd0; offset = 4'd0;

    // Asynchronous reset while beat 2 is on the output
    send32(pack32(5, 9, 3, 32'h8), 2'd0, 4'd0);
    tick(); tick(); tick();
    chk("rstmid_beat2", 80'(out_beat), 80'(2));
    rst = 1'b0;
    #1;
    chk("rstmid_valid", 80'(out_valid), 80'(0));
    chk("rstmid_data",  out_data, 80'(0));
    chk("rstmid_beat",  80'(out_beat), 80'(0));
    chk("rstmid_fcnt",  80'(frame_cnt), 80'(0));
    chk("rstmid_ready", 80'(in_ready), 80'(1));
    #1;
    rst = 1'b1;
    exp_fc = 0;
    send32(pack32(5, 9, 3, 32'h8), 2'd0, 4'd0);
    expect32("after_rst", 5, 9);

    // WC=24 instance with idx=30: every edge uses min1 and err is flagged
    in_data_b = {9'd6, 9'd2, 5'd30, 24'h000001};
    in_valid_b = 1'b1;
    chk("wc24_ready", 80'(in_ready_b), 80'(1));
    tick();
    in_valid_b = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("wc24_valid", 80'(out_valid_b), 80'(1));
      chk("wc24_err",   80'(out_err_b), 80'(1));
      chk("wc24_beat",  80'(out_beat_b), 80'(b));
      chk("wc24_last",  80'(out_last_b), 80'(b == 2));
      chk("wc24_data",  out_data_b, exp_beat(b, 6, 2, 30, 32'h1, 24));
    end
    tick();
    chk("wc24_fcnt", 80'(frame_cnt_b), 80'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
